// File: rtl/pingpong_frame_buffer_if.sv
// Writer/reader bus of the ping-pong frame buffer.
// master: drives writer/reader strobes; slave: the buffer itself.
interface pingpong_frame_buffer_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] wrAddr;
  logic              wrEn;
  logic              wrDone;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn;
  logic              rdSwitch;
  logic [DATA_W-1:0] rdData;
  logic              bankSel;
  logic              wrBankFull;
  logic              wrDrop;
  logic              underrun;
  logic [15:0]       frameCount;

  modport master (
    output wrData, wrAddr, wrEn, wrDone,
    output rdAddr, rdEn, rdSwitch,
    input  rdData, bankSel, wrBankFull,
    input  wrDrop, underrun, frameCount
  );

  modport slave (
    input  wrData, wrAddr, wrEn, wrDone,
    input  rdAddr, rdEn, rdSwitch,
    output rdData, bankSel, wrBankFull,
    output wrDrop, underrun, frameCount
  );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: writer fills bank ~bankSel, reader scans bankSel,
// swap on rdSwitch once the write bank is complete.
// Ports: clk, reset (async, active high), bus (slave modport):
//   writer wrData/wrAddr/wrEn/wrDone, reader rdAddr/rdEn/rdSwitch,
//   status rdData/bankSel/wrBankFull/wrDrop/underrun/frameCount.
// Option: PPBUF_UNDERRUN_BLANK_EN blanks reads after an underrun
// until the next successful swap.
module pingpong_frame_buffer #(
  parameter int              DATA_W    = 12,
  parameter int              ADDR_W    = 10,
  parameter int              FRAME_LEN = 1024,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input logic                    clk,
  input logic                    reset,
  pingpong_frame_buffer_if.slave bus
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {FILLING, READY} state_t;

  state_t            state;
  logic              bank_sel;
  logic [DATA_W-1:0] rd_data;
  logic              wr_drop;
  logic              under;
  logic [15:0]       frame_cnt;

  logic [DATA_W-1:0] mem0 [FRAME_LEN];
  logic [DATA_W-1:0] mem1 [FRAME_LEN];

  logic              wr_in;
  logic              rd_in;
  logic              wr_ok;
  logic              rd_fill;
  logic [DATA_W-1:0] rd_word;

`ifdef PPBUF_UNDERRUN_BLANK_EN
  logic blank;
`endif

  assign wr_in = 32'(bus.wrAddr) < FRAME_LEN;
  assign rd_in = 32'(bus.rdAddr) < FRAME_LEN;
  assign wr_ok = bus.wrEn && (state == FILLING) && wr_in;

  assign rd_word = bank_sel ? mem1[bus.rdAddr[AW-1:0]]
                            : mem0[bus.rdAddr[AW-1:0]];

`ifdef PPBUF_UNDERRUN_BLANK_EN
  assign rd_fill = blank || !rd_in;
`else
  assign rd_fill = !rd_in;
`endif

  // Bank contents survive reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (bank_sel) mem0[bus.wrAddr[AW-1:0]] <= bus.wrData;
      else          mem1[bus.wrAddr[AW-1:0]] <= bus.wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILLING;
      bank_sel  <= 1'b0;
      rd_data   <= '0;
      wr_drop   <= 1'b0;
      under     <= 1'b0;
      frame_cnt <= '0;
`ifdef PPBUF_UNDERRUN_BLANK_EN
      blank     <= 1'b0;
`endif
    end else begin
      wr_drop <= bus.wrEn && !wr_ok;
      under   <= 1'b0;
      if (bus.rdEn) rd_data <= rd_fill ? FILL_WORD : rd_word;
      unique case (state)
        FILLING: begin
          if (bus.rdSwitch && bus.wrDone) begin
            // Frame completes exactly at the boundary: swap directly.
            bank_sel  <= ~bank_sel;
            frame_cnt <= frame_cnt + 16'd1;
`ifdef PPBUF_UNDERRUN_BLANK_EN
            blank     <= 1'b0;
`endif
          end else if (bus.rdSwitch) begin
            under <= 1'b1;
`ifdef PPBUF_UNDERRUN_BLANK_EN
            blank <= 1'b1;
`endif
          end else if (bus.wrDone) begin
            state <= READY;
          end
        end
        READY: begin
          if (bus.rdSwitch) begin
            state     <= FILLING;
            bank_sel  <= ~bank_sel;
            frame_cnt <= frame_cnt + 16'd1;
`ifdef PPBUF_UNDERRUN_BLANK_EN
            blank     <= 1'b0;
`endif
          end
        end
        default: state <= FILLING;
      endcase
    end
  end

  assign bus.rdData     = rd_data;
  assign bus.bankSel    = bank_sel;
  assign bus.wrBankFull = (state == READY);
  assign bus.wrDrop     = wr_drop;
  assign bus.underrun   = under;
  assign bus.frameCount = frame_cnt;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer with a read scoreboard.
// Second instance (ADDR_W=11) covers out-of-range addresses.
module tb_pingpong_frame_buffer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pingpong_frame_buffer_if #(.DATA_W(12), .ADDR_W(10)) bus ();
  pingpong_frame_buffer_if #(.DATA_W(12), .ADDR_W(11)) bus2 ();

  pingpong_frame_buffer #(
    .DATA_W(12), .ADDR_W(10), .FRAME_LEN(1024), .FILL_WORD(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pingpong_frame_buffer #(
    .DATA_W(12), .ADDR_W(11), .FRAME_LEN(1024), .FILL_WORD(12'h5A5)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] q1 [$];
  logic [11:0] q2 [$];
  bit pend1 = 1'b0;
  bit pend2 = 1'b0;

`ifdef PPBUF_UNDERRUN_BLANK_EN
  localparam logic [11:0] UNDER_RD = 12'h000;
  localparam logic [11:0] SWAP_RD  = 12'h000;
`else
  localparam logic [11:0] UNDER_RD = 12'h0B0;
  localparam logic [11:0] SWAP_RD  = 12'h0B0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.wrEn = 1'b0; bus.wrDone = 1'b0;
    bus.rdEn = 1'b0; bus.rdSwitch = 1'b0;
    bus2.wrEn = 1'b0; bus2.wrDone = 1'b0;
    bus2.rdEn = 1'b0; bus2.rdSwitch = 1'b0;
  endtask

  task automatic rd1(input logic [9:0] a, input logic [11:0] e);
    bus.rdEn = 1'b1; bus.rdAddr = a;
    q1.push_back(e); pend1 = 1'b1;
  endtask

  task automatic rd2(input logic [10:0] a, input logic [11:0] e);
    bus2.rdEn = 1'b1; bus2.rdAddr = a;
    q2.push_back(e); pend2 = 1'b1;
  endtask

  task automatic wr1(input logic [9:0] a, input logic [11:0] d);
    bus.wrEn = 1'b1; bus.wrAddr = a; bus.wrData = d;
  endtask

  // One clock; outputs sampled 1 ns after the edge, pending reads scored.
  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
    if (pend1) begin
      pend1 = 1'b0;
      chk("rdData", 32'(bus.rdData), 32'(q1.pop_front()));
    end
    if (pend2) begin
      pend2 = 1'b0;
      chk("rdData2", 32'(bus2.rdData), 32'(q2.pop_front()));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.wrData = '0; bus.wrAddr = '0; bus.rdAddr = '0;
    bus2.wrData = '0; bus2.wrAddr = '0; bus2.rdAddr = '0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bankSel", 32'(bus.bankSel), 0);
    chk("rst_full", 32'(bus.wrBankFull), 0);
    chk("rst_rdData", 32'(bus.rdData), 0);
    chk("rst_frameCount", 32'(bus.frameCount), 0);
    reset = 1'b0;
    step();

    // Fill bank 1; last write shares its cycle with wrDone.
    for (int i = 0; i < 1024; i++) begin
      wr1(10'(i), 12'(12'h0AB + i));
      if (i == 1023) bus.wrDone = 1'b1;
      step();
    end
    chk("full_set", 32'(bus.wrBankFull), 1);
    chk("no_drop", 32'(bus.wrDrop), 0);

    // Write while full is dropped.
    wr1(10'd7, 12'hFFF);
    step();
    chk("drop_pulse", 32'(bus.wrDrop), 1);
    bus.wrDone = 1'b1;
    step();
    chk("drop_end", 32'(bus.wrDrop), 0);
    chk("done_ready", 32'(bus.wrBankFull), 1);
    step();
    chk("done_ready_nodrop", 32'(bus.wrDrop), 0);

    // Swap.
    bus.rdSwitch = 1'b1;
    step();
    chk("swap_bankSel", 32'(bus.bankSel), 1);
    chk("swap_full", 32'(bus.wrBankFull), 0);
    chk("swap_count", 32'(bus.frameCount), 1);
    chk("swap_under", 32'(bus.underrun), 0);
    rd1(10'd5, 12'h0B0);
    step();
    rd1(10'd7, 12'h0B2);
    step();
    chk("rd_hold", 32'(bus.rdData), 32'h0B2);
    rd1(10'd1023, 12'h4AA);
    step();

    // Underrun.
    bus.rdSwitch = 1'b1;
    step();
    chk("under_pulse", 32'(bus.underrun), 1);
    chk("under_bankSel", 32'(bus.bankSel), 1);
    step();
    chk("under_end", 32'(bus.underrun), 0);
    rd1(10'd5, UNDER_RD);
    step();

    // Partial frame into bank 0, then wrDone with rdSwitch together.
    wr1(10'd5, 12'h123);
    step();
    bus.wrDone = 1'b1; bus.rdSwitch = 1'b1;
    rd1(10'd5, SWAP_RD);
    step();
    chk("combo_bankSel", 32'(bus.bankSel), 0);
    chk("combo_under", 32'(bus.underrun), 0);
    chk("combo_full", 32'(bus.wrBankFull), 0);
    chk("combo_count", 32'(bus.frameCount), 2);
    rd1(10'd5, 12'h123);
    step();

    // Read in the swap cycle sees the pre-swap bank.
    wr1(10'd5, 12'h321);
    bus.wrDone = 1'b1;
    step();
    bus.rdSwitch = 1'b1;
    rd1(10'd5, 12'h123);
    step();
    chk("pre_bankSel", 32'(bus.bankSel), 1);
    chk("pre_count", 32'(bus.frameCount), 3);
    rd1(10'd5, 12'h321);
    step();

    // Mid-frame async reset.
    wr1(10'd9, 12'h999);
    step();
    wr1(10'd10, 12'h998);
    bus.wrDone = 1'b1;
    step();
    chk("pre_rst_full", 32'(bus.wrBankFull), 1);
    reset = 1'b1;
    #2;
    chk("arst_bankSel", 32'(bus.bankSel), 0);
    chk("arst_full", 32'(bus.wrBankFull), 0);
    chk("arst_rdData", 32'(bus.rdData), 0);
    chk("arst_drop", 32'(bus.wrDrop), 0);
    chk("arst_under", 32'(bus.underrun), 0);
    chk("arst_count", 32'(bus.frameCount), 0);
    step();
    reset = 1'b0;
    step();

    // Writer restarts in bank 1.
    wr1(10'd5, 12'h456);
    bus.wrDone = 1'b1;
    step();
    bus.rdSwitch = 1'b1;
    step();
    rd1(10'd5, 12'h456);
    step();
    chk("restart_count", 32'(bus.frameCount), 1);

    // Counter wrap: 65535 more swaps.
    for (int i = 0; i < 65534; i++) begin
      bus.wrDone = 1'b1; bus.rdSwitch = 1'b1;
      step();
    end
    chk("cnt_ffff", 32'(bus.frameCount), 32'hFFFF);
    bus.wrDone = 1'b1; bus.rdSwitch = 1'b1;
    step();
    chk("cnt_wrap", 32'(bus.frameCount), 0);
    chk("wrap_bankSel", 32'(bus.bankSel), 0);

    // Out-of-range addresses on the 11-bit instance.
    bus2.wrEn = 1'b1; bus2.wrAddr = 11'd3; bus2.wrData = 12'h777;
    step();
    chk("oor_nodrop", 32'(bus2.wrDrop), 0);
    bus2.wrEn = 1'b1; bus2.wrAddr = 11'd1024; bus2.wrData = 12'h111;
    step();
    chk("oor_drop", 32'(bus2.wrDrop), 1);
    bus2.wrDone = 1'b1; bus2.rdSwitch = 1'b1;
    step();
    chk("oor_bankSel", 32'(bus2.bankSel), 1);
    rd2(11'd3, 12'h777);
    step();
    rd2(11'd1024, 12'h5A5);
    step();
    rd2(11'd2047, 12'h5A5);
    step();

    chk("q_empty", 32'(q1.size() + q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
